popcount_seq: RTL and testbench
===============================

# popcount_seq

Parametrised, multi-cycle population counter for the approximate-popcount neuron datapath. It accepts a WIDTH-bit input vector over a valid/ready handshake and sums its set bits CHUNK bits per cycle in a small accumulator. It returns the exact count over a second valid/ready handshake. It sits between the input-vector register and the neuron activation stage, and trades latency for area against the single-cycle combinational popcount blocks.

## Interface
- WIDTH, 28, number of input bits counted (≥1)
- CHUNK, 7, bits summed per accumulate cycle (1..WIDTH)
- NCH (localparam), ceil(WIDTH/CHUNK), accumulate cycles per vector
- OW (localparam), $clog2(WIDTH+1), count width (28 → 5)
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- input_a  input  WIDTH  vector to count
- in_valid  input  1  input_a valid
- in_ready  output  1  block can accept a vector
- popcount_seq_out  output  OW  count result
- out_valid  output  1  popcount_seq_out valid
- out_ready  input  1  consumer accepts result
- thr  input  OW  threshold, captured with input_a (POPCOUNT_SEQ_THRESH_EN only)
- popcount_seq_ge  output  1  result ≥ captured thr (POPCOUNT_SEQ_THRESH_EN only)

## Operation
- FSM states: IDLE, ACC, DONE. Reset state: IDLE.
- IDLE: in_ready=1, out_valid=0. When in_valid is high at an edge:
  - load input_a into the shift register (zero-extended to NCH*CHUNK bits)
  - clear the accumulator and the chunk counter
  - go to ACC
- ACC: in_ready=0.
  - Each cycle, add the popcount of the low CHUNK bits of the shift register to the accumulator.
  - Then shift the register right by CHUNK and increment the counter.
  - After the NCH-th add, go to DONE.
- DONE: out_valid=1, in_ready=0. popcount_seq_out holds the final count. When out_ready is high at an edge, go to IDLE.
- popcount_seq_out is driven directly by the accumulator. Its value is valid only while out_valid=1 and holds stable for the whole of DONE.
- Arithmetic: the accumulator is OW bits wide. The count cannot exceed WIDTH, so overflow is impossible. Chunk adders are $clog2(CHUNK+1) bits, zero-extended before the add.
- Padding: when WIDTH is not a multiple of CHUNK, the top chunk is zero-padded and contributes nothing.
- in_valid is ignored outside IDLE. Asserting in_valid in ACC or DONE causes no effect and no capture.
- out_ready is ignored outside DONE.
- rst has priority over all other events, including in the same cycle as a handshake. It forces:
  - state IDLE
  - accumulator and counter 0
  - out_valid 0, in_ready 1 from the next cycle
  - any vector in flight is discarded

## Timing
- Reset values: in_ready=1, out_valid=0, popcount_seq_out=0, popcount_seq_ge=0.
- Input accepted at edge E0 (in_valid & in_ready). out_valid rises after edge E0+NCH, giving a latency of NCH cycles (4 with defaults).
- Result accepted at edge Ed (out_valid & out_ready). in_ready=1 in the following cycle. The earliest next accept is at edge Ed+1.
- Peak throughput is one vector per NCH+2 cycles (6 with defaults).
- No combinational path from any input to any output.

## Configuration
- POPCOUNT_SEQ_THRESH_EN defined:
  - the thr port and an OW-bit thr register are present; thr is captured on input accept
  - popcount_seq_ge = (accumulator ≥ captured thr), registered, valid with out_valid, 0 on reset
- POPCOUNT_SEQ_THRESH_EN undefined: the thr and popcount_seq_ge ports and their logic are absent. Count behaviour is identical in both builds.

## Test plan
- Defaults, input_a=0 accepted at E0 → out_valid after E0+4, popcount_seq_out=0. input_a=28'hFFFFFFF → 28.
- input_a=28'hAAAAAAA → 14. input_a=28'h8000001 → 2. No handshake glitches with out_ready tied high; next in_ready one cycle after result accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → popcount_seq_out stable, in_ready=0, in_valid pulses ignored; then out_ready=1 → IDLE next cycle.
- rst pulsed during the 2nd ACC cycle → next cycle IDLE, out_valid=0, popcount_seq_out=0. A following vector 28'h000000F counts correctly as 4.
- WIDTH=10, CHUNK=4 (NCH=3, padded): input_a=10'h3FF → 10 after 3 cycles. WIDTH=28, CHUNK=28 → 1-cycle latency.
- With POPCOUNT_SEQ_THRESH_EN:
  - thr=14, input_a=28'hAAAAAAA → popcount_seq_ge=1
  - thr=15, same input → popcount_seq_ge=0
  - thr=0, input_a=0 → popcount_seq_ge=1

Source files
------------

// File: rtl/popcount_seq.sv
// Multi-cycle population counter: sums CHUNK bits of a WIDTH-bit vector per cycle.
// Optional threshold compare enabled by defining POPCOUNT_SEQ_THRESH_EN.
module popcount_seq #(
  parameter  int WIDTH = 28,
  parameter  int CHUNK = 7,
  localparam int NCH   = (WIDTH + CHUNK - 1) / CHUNK,
  localparam int OW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_a,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OW-1:0]    popcount_seq_out,
  output logic             out_valid,
`ifdef POPCOUNT_SEQ_THRESH_EN
  input  logic [OW-1:0]    thr,
  output logic             popcount_seq_ge,
`endif
  input  logic             out_ready
);

  localparam int SW   = NCH * CHUNK;
  localparam int CW   = $clog2(CHUNK + 1);
  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   sr;
  logic [OW-1:0]   acc;
  logic [OW-1:0]   acc_next;
  logic [CNTW-1:0] cnt;
  logic            accept;
  logic            last;

  function automatic logic [CW-1:0] chunk_pop(input logic [CHUNK-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  assign accept   = (state == IDLE) && in_valid;
  assign last     = (cnt == CNTW'(NCH - 1));
  assign acc_next = acc + OW'(chunk_pop(sr[CHUNK-1:0]));

  assign in_ready         = (state == IDLE);
  assign out_valid        = (state == DONE);
  assign popcount_seq_out = acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = ACC;
      ACC:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Top chunk is zero-padded by the widening cast, so it adds nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= SW'(input_a);
      acc <= '0;
      cnt <= '0;
    end else if (state == ACC) begin
      sr  <= sr >> CHUNK;
      acc <= acc_next;
      cnt <= cnt + CNTW'(1);
    end
  end

`ifdef POPCOUNT_SEQ_THRESH_EN
  logic [OW-1:0] thr_q;

  // Compare resolves on the final add so it is ready together with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q           <= '0;
      popcount_seq_ge <= 1'b0;
    end else if (accept) begin
      thr_q           <= thr;
      popcount_seq_ge <= 1'b0;
    end else if (state == ACC && last) begin
      popcount_seq_ge <= (acc_next >= thr_q);
    end
  end
`endif

endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq: random vectors against a $countones model,
// covering latency, handshakes, backpressure, mid-flight reset and padded configs.
module tb_popcount_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] input_a = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  pc_out;

  logic [9:0]  p_a = '0;
  logic        p_in_valid = 1'b0;
  logic        p_out_ready = 1'b0;
  logic        p_in_ready;
  logic        p_out_valid;
  logic [3:0]  p_out;

  logic [27:0] o_a = '0;
  logic        o_in_valid = 1'b0;
  logic        o_out_ready = 1'b0;
  logic        o_in_ready;
  logic        o_out_valid;
  logic [4:0]  o_out;

`ifdef POPCOUNT_SEQ_THRESH_EN
  logic [4:0]  thr = '0;
  logic        ge;
  logic        last_ge;
  logic        p_ge;
  logic        o_ge;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  popcount_seq #(.WIDTH(28), .CHUNK(7)) dut (
    .clk(clk), .rst(rst), .input_a(input_a), .in_valid(in_valid), .in_ready(in_ready),
    .popcount_seq_out(pc_out), .out_valid(out_valid),
`ifdef POPCOUNT_SEQ_THRESH_EN
    .thr(thr), .popcount_seq_ge(ge),
`endif
    .out_ready(out_ready)
  );

  popcount_seq #(.WIDTH(10), .CHUNK(4)) dut_pad (
    .clk(clk), .rst(rst), .input_a(p_a), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .popcount_seq_out(p_out), .out_valid(p_out_valid),
`ifdef POPCOUNT_SEQ_THRESH_EN
    .thr(4'd0), .popcount_seq_ge(p_ge),
`endif
    .out_ready(p_out_ready)
  );

  popcount_seq #(.WIDTH(28), .CHUNK(28)) dut_one (
    .clk(clk), .rst(rst), .input_a(o_a), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .popcount_seq_out(o_out), .out_valid(o_out_valid),
`ifdef POPCOUNT_SEQ_THRESH_EN
    .thr(5'd0), .popcount_seq_ge(o_ge),
`endif
    .out_ready(o_out_ready)
  );

  // Drives one transaction on the main instance: accept, wait (bounded), consume.
  task automatic run_main(input logic [27:0] v, output int lat, output logic [4:0] res);
    input_a = v; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = pc_out;
`ifdef POPCOUNT_SEQ_THRESH_EN
    last_ge = ge;
`endif
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic run_pad(input logic [9:0] v, output int lat, output logic [3:0] res);
    p_a = v; p_in_valid = 1'b1;
    @(negedge clk); p_in_valid = 1'b0; lat = 0;
    while (!p_out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = p_out;
    p_out_ready = 1'b1;
    @(negedge clk); p_out_ready = 1'b0;
  endtask

  task automatic run_one(input logic [27:0] v, output int lat, output logic [4:0] res);
    o_a = v; o_in_valid = 1'b1;
    @(negedge clk); o_in_valid = 1'b0; lat = 0;
    while (!o_out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = o_out;
    o_out_ready = 1'b1;
    @(negedge clk); o_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || pc_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b out=%0d required 1 0 0",
               in_ready, out_valid, pc_out);
    end
`ifdef POPCOUNT_SEQ_THRESH_EN
    vectors++;
    if (ge !== 1'b0) begin errors++; $display("FAIL reset_ge got %b required 0", ge); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [27:0] table_v [4] = '{28'h0000000, 28'hFFFFFFF, 28'hAAAAAAA, 28'h8000001};
    logic [27:0] v;
    logic [4:0]  res;
    int          lat;
    int          exp_cnt;
    for (int i = 0; i < 24; i++) begin
      v = (i < 4) ? table_v[i] : ((i % 3 == 0) ? 28'($urandom) & 28'($urandom) : 28'($urandom));
      exp_cnt = $countones(v);
`ifdef POPCOUNT_SEQ_THRESH_EN
      thr = 5'($urandom_range(0, 28));
`endif
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_before got %b required 1", in_ready); end
      run_main(v, lat, res);
      vectors++;
      if (lat !== 4) begin errors++; $display("FAIL basic_latency v=%h got %0d required 4", v, lat); end
      vectors++;
      if (res !== 5'(exp_cnt)) begin errors++; $display("FAIL basic_count v=%h got %0d required %0d", v, res, exp_cnt); end
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_after_accept in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
`ifdef POPCOUNT_SEQ_THRESH_EN
      vectors++;
      if (last_ge !== (exp_cnt >= int'(thr))) begin
        errors++;
        $display("FAIL basic_ge v=%h thr=%0d got %b required %b", v, thr, last_ge, exp_cnt >= int'(thr));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int last_acc = -1;
    int exp_cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    input_a   = 28'($urandom);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_valid cycle=%0d got out_valid=1 required 0", cyc);
        end else begin
          exp_cnt = exp_q.pop_front();
          if (pc_out !== 5'(exp_cnt)) begin errors++; $display("FAIL b2b_count got %0d required %0d", pc_out, exp_cnt); end
        end
      end
      if (in_ready) begin
        exp_q.push_back($countones(input_a));
        if (last_acc >= 0) begin
          vectors++;
          if (cyc - last_acc != 6) begin errors++; $display("FAIL b2b_period got %0d required 6", cyc - last_acc); end
        end
        last_acc = cyc;
      end else begin
        input_a = 28'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid && exp_q.size() > 0) begin
        exp_cnt = exp_q.pop_front();
        vectors++;
        if (pc_out !== 5'(exp_cnt)) begin errors++; $display("FAIL b2b_drain_count got %0d required %0d", pc_out, exp_cnt); end
      end
      @(negedge clk);
    end
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_results got %0d pending required 0", exp_q.size()); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat = 0;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before got %b required 1", in_ready); end
    input_a = 28'hAAAAAAA; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    vectors++;
    if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d required 4", lat); end
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      input_a  = 28'($urandom);
      @(negedge clk);
      vectors++;
      if (pc_out !== 5'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d out=%0d out_valid=%b in_ready=%b required 14 1 0",
                 k, pc_out, out_valid, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] res;
    int         lat;
    input_a = 28'($urandom) | 28'h1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || pc_out !== 5'd0) begin
      errors++;
      $display("FAIL midreset_state in_ready=%b out_valid=%b out=%0d required 1 0 0", in_ready, out_valid, pc_out);
    end
    run_main(28'h000000F, lat, res);
    vectors++;
    if (lat !== 4 || res !== 5'd4) begin
      errors++; $display("FAIL midreset_next latency=%0d count=%0d required 4 4", lat, res);
    end
  endtask

  task automatic test_padded();
    logic [9:0] v;
    logic [3:0] res;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 10'h3FF : 10'($urandom);
      run_pad(v, lat, res);
      vectors++;
      if (lat !== 3 || res !== 4'($countones(v))) begin
        errors++;
        $display("FAIL padded v=%h latency=%0d count=%0d required 3 %0d", v, lat, res, $countones(v));
      end
    end
  endtask

  task automatic test_single_chunk();
    logic [27:0] v;
    logic [4:0]  res;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 28'hFFFFFFF : 28'($urandom);
      run_one(v, lat, res);
      vectors++;
      if (lat !== 1 || res !== 5'($countones(v))) begin
        errors++;
        $display("FAIL single_chunk v=%h latency=%0d count=%0d required 1 %0d", v, lat, res, $countones(v));
      end
    end
  endtask

`ifdef POPCOUNT_SEQ_THRESH_EN
  task automatic test_thresh();
    logic [27:0] tv [3] = '{28'hAAAAAAA, 28'hAAAAAAA, 28'h0000000};
    logic [4:0]  tt [3] = '{5'd14, 5'd15, 5'd0};
    logic        te [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  res;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      thr = tt[i];
      run_main(tv[i], lat, res);
      vectors++;
      if (last_ge !== te[i]) begin
        errors++; $display("FAIL thresh thr=%0d v=%h got %b required %b", tt[i], tv[i], last_ge, te[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_padded();
    test_single_chunk();
`ifdef POPCOUNT_SEQ_THRESH_EN
    test_thresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
